// File: rtl/koopa_sprite_pkg.sv
// Shared constants and types for the koopa sprite fetch pipeline.
package koopa_sprite_pkg;

    localparam int FRAME_W     = 23;
    localparam int FRAME_H     = 30;
    localparam int SHEET_LOG2W = 8;
    localparam int SCR_W       = 10;
    localparam int RGB_W       = 12;
    localparam logic [RGB_W-1:0] TRANSP = 12'hF0F;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACTIVE     = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [SHEET_LOG2W-1:0] row;
        logic [SHEET_LOG2W-1:0] col;
        logic [SCR_W-1:0]       x;
        logic [SCR_W-1:0]       y;
        logic                   flip;
    } sprite_latch_t;

endpackage

// File: rtl/koopa_sprite_addr_gen.sv
// Combinational hit test and sprite-sheet address generation for one draw pixel.
module koopa_sprite_addr_gen
    import koopa_sprite_pkg::*;
(
    input  logic                       active,
    input  logic                       draw_en,
    input  logic [SCR_W-1:0]           draw_x,
    input  logic [SCR_W-1:0]           draw_y,
    input  sprite_latch_t              lat,
    output logic                       hit,
    output logic [2*SHEET_LOG2W-1:0]   addr
);

    localparam logic [SCR_W:0] FW      = (SCR_W+1)'(FRAME_W);
    localparam logic [SCR_W:0] FH      = (SCR_W+1)'(FRAME_H);
    localparam logic [SCR_W:0] SHEET_N = (SCR_W+1)'(2**SHEET_LOG2W);

    logic [SCR_W:0] dx;
    logic [SCR_W:0] dy;
    logic [SCR_W:0] cx;
    logic [SCR_W:0] row_sum;
    logic [SCR_W:0] col_sum;
    logic           in_box;
    logic           on_sheet;

    // Sums are kept at screen width so any carry past the sheet edge is visible.
    always_comb begin
        dx       = {1'b0, draw_x} - {1'b0, lat.x};
        dy       = {1'b0, draw_y} - {1'b0, lat.y};
        in_box   = !dx[SCR_W] && !dy[SCR_W] && (dx < FW) && (dy < FH);
        cx       = lat.flip ? (FW - 1'b1 - dx) : dx;
        row_sum  = (SCR_W+1)'(lat.row) + dy;
        col_sum  = (SCR_W+1)'(lat.col) + cx;
        on_sheet = (row_sum < SHEET_N) && (col_sum < SHEET_N);
        hit      = active && draw_en && in_box && on_sheet;
        addr     = {row_sum[SHEET_LOG2W-1:0], col_sum[SHEET_LOG2W-1:0]};
    end

endmodule

// File: rtl/koopa_sprite_fetch.sv
// Koopa sprite fetch: frame-origin latch, frame FSM and 3-stage ROM pixel pipeline.
//   state      | meaning
//   WAIT_FRAME | no frame latched yet, all hits suppressed
//   ACTIVE     | latched origin valid, drawing enabled
module koopa_sprite_fetch
    import koopa_sprite_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       frame_start,
    input  logic [SHEET_LOG2W-1:0]     anim_row,
    input  logic [SHEET_LOG2W-1:0]     anim_col,
    input  logic [SCR_W-1:0]           pos_x,
    input  logic [SCR_W-1:0]           pos_y,
    input  logic                       flip_h,
    input  logic                       draw_en,
    input  logic [SCR_W-1:0]           draw_x,
    input  logic [SCR_W-1:0]           draw_y,
    output logic [2*SHEET_LOG2W-1:0]   rom_addr,
    input  logic [RGB_W-1:0]           rom_data,
    output logic [RGB_W-1:0]           pix_rgb,
    output logic                       pix_valid
);

    fetch_state_t                 state;
    fetch_state_t                 next_state;
    sprite_latch_t                lat;
    logic                         hit0;
    logic [2*SHEET_LOG2W-1:0]     addr0;
    logic                         hit1;
    logic                         hit2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= WAIT_FRAME;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            WAIT_FRAME: if (frame_start) next_state = ACTIVE;
            ACTIVE:     next_state = ACTIVE;
            default:    next_state = WAIT_FRAME;
        endcase
    end

    // Origin, position and flip only move at frame start so a scan never tears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat <= '0;
        end else if (frame_start) begin
            lat.row  <= anim_row;
            lat.col  <= anim_col;
            lat.x    <= pos_x;
            lat.y    <= pos_y;
            lat.flip <= flip_h;
        end
    end

    koopa_sprite_addr_gen u_addr_gen (
        .active  (state == ACTIVE),
        .draw_en (draw_en),
        .draw_x  (draw_x),
        .draw_y  (draw_y),
        .lat     (lat),
        .hit     (hit0),
        .addr    (addr0)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr  <= '0;
            hit1      <= 1'b0;
            hit2      <= 1'b0;
            pix_valid <= 1'b0;
            pix_rgb   <= '0;
        end else begin
            hit1 <= hit0;
            if (hit0) rom_addr <= addr0;
            hit2      <= hit1;
            pix_valid <= hit2 && (rom_data != TRANSP);
            pix_rgb   <= hit2 ? rom_data : '0;
        end
    end

endmodule

// File: tb/tb_koopa_sprite_fetch.sv
// Directed bench for koopa_sprite_fetch with a one-cycle-latency ROM model.
module tb_koopa_sprite_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic [7:0]  anim_row;
    logic [7:0]  anim_col;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        flip_h;
    logic        draw_en;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic [15:0] rom_addr;
    logic [11:0] rom_data;
    logic [11:0] pix_rgb;
    logic        pix_valid;
    logic [11:0] rom_word;

    int n_cmp = 0;
    int n_bad = 0;

    koopa_sprite_fetch dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .anim_row    (anim_row),
        .anim_col    (anim_col),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .flip_h      (flip_h),
        .draw_en     (draw_en),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pix_rgb     (pix_rgb),
        .pix_valid   (pix_valid)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= rom_word;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic pulse_frame(input logic [7:0] r, input logic [7:0] c,
                               input logic [9:0] x, input logic [9:0] y, input logic f);
        frame_start = 1'b1;
        anim_row = r; anim_col = c; pos_x = x; pos_y = y; flip_h = f;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Entered at a negedge; checks rom_addr at N+1 and pixel outputs at N+3.
    task automatic pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                         input logic exp_v, input logic [15:0] exp_a, input logic [11:0] exp_rgb);
        draw_en = 1'b1; draw_x = x; draw_y = y;
        @(negedge clk);
        draw_en = 1'b0;
        chk_val({tag, "_addr"}, 32'(rom_addr), 32'(exp_a));
        @(negedge clk);
        @(negedge clk);
        chk_val({tag, "_valid"}, 32'(pix_valid), 32'(exp_v));
        chk_val({tag, "_rgb"}, 32'(pix_rgb), 32'(exp_rgb));
    endtask

    initial begin
        reset_n = 1'b0; frame_start = 1'b0; anim_row = 8'd150; anim_col = 8'd23;
        pos_x = 10'd100; pos_y = 10'd50; flip_h = 1'b0;
        draw_en = 1'b0; draw_x = '0; draw_y = '0; rom_word = 12'h0A5;
        #23;
        chk_val("rst_addr", 32'(rom_addr), 32'd0);
        chk_val("rst_valid", 32'(pix_valid), 32'd0);
        chk_val("rst_rgb", 32'(pix_rgb), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // No frame latched yet: every draw must be suppressed.
        draw_en = 1'b1; draw_x = 10'd100; draw_y = 10'd50;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_val("noframe_valid", 32'(pix_valid), 32'd0);
        end
        draw_en = 1'b0;

        pulse_frame(8'd150, 8'd23, 10'd100, 10'd50, 1'b0);
        pixel("origin", 10'd100, 10'd50, 1'b1, 16'd38423, 12'h0A5);
        pulse_frame(8'd150, 8'd23, 10'd100, 10'd50, 1'b1);
        pixel("flip", 10'd100, 10'd50, 1'b1, 16'd38445, 12'h0A5);
        pulse_frame(8'd150, 8'd23, 10'd100, 10'd50, 1'b0);
        pixel("corner", 10'd122, 10'd79, 1'b1, 16'd45869, 12'h0A5);

        pixel("miss_right", 10'd123, 10'd50, 1'b0, 16'd45869, 12'h000);
        pixel("miss_left", 10'd99, 10'd50, 1'b0, 16'd45869, 12'h000);
        pixel("miss_below", 10'd100, 10'd80, 1'b0, 16'd45869, 12'h000);
        pixel("miss_above", 10'd100, 10'd49, 1'b0, 16'd45869, 12'h000);

        rom_word = 12'hF0F;
        pixel("transp", 10'd100, 10'd50, 1'b0, 16'd38423, 12'hF0F);
        rom_word = 12'h0A5;

        anim_row = 8'd180;
        pixel("nolatch", 10'd100, 10'd50, 1'b1, 16'd38423, 12'h0A5);
        pulse_frame(8'd180, 8'd23, 10'd100, 10'd50, 1'b0);
        pixel("relatch", 10'd100, 10'd50, 1'b1, 16'd46103, 12'h0A5);

        // Draw coincident with the pulse still sees the previous origin (row 180).
        frame_start = 1'b1; anim_row = 8'd150;
        draw_en = 1'b1; draw_x = 10'd100; draw_y = 10'd50;
        @(negedge clk);
        frame_start = 1'b0; draw_en = 1'b0;
        chk_val("same_cycle_addr", 32'(rom_addr), 32'd46103);
        pixel("after_same", 10'd100, 10'd50, 1'b1, 16'd38423, 12'h0A5);

        // Row sum 240+20 runs off the sheet; 240+15 just fits.
        pulse_frame(8'd240, 8'd23, 10'd100, 10'd50, 1'b0);
        pixel("carry_miss", 10'd100, 10'd70, 1'b0, 16'd38423, 12'h000);
        pixel("carry_edge", 10'd100, 10'd65, 1'b1, 16'd65303, 12'h0A5);

        pulse_frame(8'd150, 8'd23, 10'd100, 10'd50, 1'b0);
        for (int k = 0; k < 4; k++) begin
            draw_en = 1'b1; draw_x = 10'(100 + k); draw_y = 10'd50;
            @(negedge clk);
        end
        chk_val("burst_valid", 32'(pix_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_val("midrst_valid", 32'(pix_valid), 32'd0);
        chk_val("midrst_addr", 32'(rom_addr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_val("postrst_valid", 32'(pix_valid), 32'd0);
        end
        draw_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
